// File: rtl/garrafas_pkg.sv
// Shared types and defaults for the bottle filling line controller.
package garrafas_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StAdvance   = 3'd1,
        StFill      = 3'd2,
        StSeal      = 3'd3,
        StCount     = 3'd4,
        StCrateWait = 3'd5,
        StFault     = 3'd6
    } line_state_e;

    localparam int unsigned DefFillTimeout = 200;
    localparam int unsigned DefSealCycles  = 8;
    localparam int unsigned DefCrateSize   = 10;

    // Wide enough to hold the larger of the two terminal counts.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/line_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
module line_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic [Width-1:0] terminal_i,
    output logic [Width-1:0] count_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign tc_o    = (cnt_q == terminal_i);

endmodule

// File: rtl/bottle_line_controller.sv
// Bottle line sequencer: advance, fill, seal, count into crates, with fill-timeout fault.
module bottle_line_controller
    import garrafas_pkg::*;
#(
    parameter int unsigned FILL_TIMEOUT = DefFillTimeout,
    parameter int unsigned SEAL_CYCLES  = DefSealCycles,
    parameter int unsigned CRATE_SIZE   = DefCrateSize
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       bottle_at_fill,
    input  logic       level_full,
    input  logic       crate_ack,
    input  logic       clear_fault,
    output logic       conveyor_on,
    output logic       valve_open,
    output logic       cap_press,
    output logic       bottle_done,
    output logic       crate_full,
    output logic       alarm,
    output logic [3:0] count
);

    localparam int unsigned TimerW   = timer_width(FILL_TIMEOUT, SEAL_CYCLES);
    localparam logic [3:0]  CountMax = 4'(CRATE_SIZE - 1);

    line_state_e state_d, state_q;
    logic        bottle_q;
    logic        stop_pending_d, stop_pending_q;
    logic [3:0]  count_d, count_q;

    logic              bottle_rise;
    logic              stop_eff;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_tc;
    logic [TimerW-1:0] timer_terminal;
    logic [TimerW-1:0] timer_count;

    assign bottle_rise = bottle_at_fill & ~bottle_q;
    // A stop seen in the deciding cycle counts as already pending.
    assign stop_eff    = stop_pending_q | stop;

    assign timer_clear    = (state_d != state_q);
    assign timer_en       = (state_q == StFill) || (state_q == StSeal);
    assign timer_terminal = (state_q == StFill) ? TimerW'(FILL_TIMEOUT - 1)
                                                : TimerW'(SEAL_CYCLES - 1);

    line_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (timer_clear),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (timer_en),
        .terminal_i (timer_terminal),
        .count_o    (timer_count),
        .tc_o       (timer_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start && !stop) state_d = StAdvance;
            end
            StAdvance: begin
                if (stop)             state_d = StIdle;
                else if (bottle_rise) state_d = StFill;
            end
            StFill: begin
                if (level_full)    state_d = StSeal;
                else if (timer_tc) state_d = StFault;
            end
            StSeal: begin
                if (timer_tc) state_d = StCount;
            end
            StCount: begin
                // count was advanced on entry, so zero here means the crate just filled.
                if (count_q == 4'd0) state_d = StCrateWait;
                else if (stop_eff)   state_d = StIdle;
                else                 state_d = StAdvance;
            end
            StCrateWait: begin
                if (crate_ack) state_d = stop_eff ? StIdle : StAdvance;
            end
            StFault: begin
                if (clear_fault) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stop_pending_d = stop_pending_q;
        if (state_d == StIdle) begin
            stop_pending_d = 1'b0;
        end else if (stop && (state_q == StFill || state_q == StSeal ||
                              state_q == StCount || state_q == StCrateWait)) begin
            stop_pending_d = 1'b1;
        end
    end

    // Advance on the edge into COUNT so bottle_done and the new count appear together.
    always_comb begin
        count_d = count_q;
        if (state_q == StSeal && state_d == StCount) begin
            count_d = (count_q == CountMax) ? 4'd0 : count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            bottle_q       <= 1'b0;
            stop_pending_q <= 1'b0;
            count_q        <= 4'd0;
        end else begin
            state_q        <= state_d;
            bottle_q       <= bottle_at_fill;
            stop_pending_q <= stop_pending_d;
            count_q        <= count_d;
        end
    end

    assign conveyor_on = (state_q == StAdvance);
    assign valve_open  = (state_q == StFill);
    assign cap_press   = (state_q == StSeal);
    assign bottle_done = (state_q == StCount);
    assign crate_full  = (state_q == StCrateWait);
    assign alarm       = (state_q == StFault);
    assign count       = count_q;

endmodule

// File: tb/tb_bottle_line_controller.sv
// Directed bench for bottle_line_controller; outputs packed as {6 actuator bits, count}.
module tb_bottle_line_controller;

    localparam logic [5:0] OnNone  = 6'b000000;
    localparam logic [5:0] OnAdv   = 6'b100000;
    localparam logic [5:0] OnFill  = 6'b010000;
    localparam logic [5:0] OnSeal  = 6'b001000;
    localparam logic [5:0] OnDone  = 6'b000100;
    localparam logic [5:0] OnFull  = 6'b000010;
    localparam logic [5:0] OnAlarm = 6'b000001;

    logic       clk = 1'b0;
    logic       reset, start, stop, bottle_at_fill, level_full, crate_ack, clear_fault;
    logic       conveyor_on, valve_open, cap_press, bottle_done, crate_full, alarm;
    logic [3:0] count;

    int n_vectors     = 0;
    int n_miscompares = 0;

    bottle_line_controller dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .bottle_at_fill (bottle_at_fill),
        .level_full     (level_full),
        .crate_ack      (crate_ack),
        .clear_fault    (clear_fault),
        .conveyor_on    (conveyor_on),
        .valve_open     (valve_open),
        .cap_press      (cap_press),
        .bottle_done    (bottle_done),
        .crate_full     (crate_full),
        .alarm          (alarm),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {conveyor_on, valve_open, cap_press, bottle_done, crate_full, alarm, count};
    endfunction

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bottle from ADVANCE: prev is the count before, fill_wait the FILL cycles
    // before level_full rises, to_idle pulses stop during FILL.
    task automatic run_bottle(input logic [3:0] prev, input int fill_wait, input bit to_idle);
        logic [3:0] nxt;
        logic [5:0] after;
        nxt   = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
        after = (prev == 4'd9) ? OnFull : (to_idle ? OnNone : OnAdv);
        bottle_at_fill = 1'b1;
        step(1);
        check_eq("fill_entry", outs(), {OnFill, prev});
        if (to_idle) stop = 1'b1;
        for (int i = 1; i < fill_wait; i++) begin
            step(1);
            stop = 1'b0;
            check_eq("fill_hold", outs(), {OnFill, prev});
        end
        level_full = 1'b1;
        step(1);
        level_full = 1'b0;
        check_eq("seal_entry", outs(), {OnSeal, prev});
        for (int i = 1; i < 8; i++) begin
            step(1);
            check_eq("seal_hold", outs(), {OnSeal, prev});
        end
        step(1);
        check_eq("done_pulse", outs(), {OnDone, nxt});
        step(1);
        check_eq("after_count", outs(), {after, nxt});
        step(2);
        check_eq("no_retrigger", outs(), {after, nxt});
        bottle_at_fill = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; stop = 1'b0; bottle_at_fill = 1'b0;
        level_full = 1'b0; crate_ack = 1'b0; clear_fault = 1'b0;
        step(2);
        check_eq("reset_state", outs(), {OnNone, 4'd0});
        reset = 1'b1;
        step(1);
        check_eq("start_advance", outs(), {OnAdv, 4'd0});
        start = 1'b0;

        run_bottle(4'd0, 5, 1'b0);

        // Fill timeout: 200 FILL cycles, then fault with count kept.
        bottle_at_fill = 1'b1;
        step(1);
        check_eq("to_fill", outs(), {OnFill, 4'd1});
        step(199);
        check_eq("fill_cycle_200", outs(), {OnFill, 4'd1});
        step(1);
        check_eq("fault", outs(), {OnAlarm, 4'd1});
        bottle_at_fill = 1'b0;
        step(3);
        check_eq("fault_hold", outs(), {OnAlarm, 4'd1});
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        check_eq("fault_clear", outs(), {OnNone, 4'd1});
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_eq("restart", outs(), {OnAdv, 4'd1});

        for (int b = 1; b < 10; b++) run_bottle(4'(b), 1, 1'b0);

        step(3);
        check_eq("crate_hold", outs(), {OnFull, 4'd0});
        crate_ack = 1'b1;
        step(1);
        crate_ack = 1'b0;
        check_eq("crate_ack", outs(), {OnAdv, 4'd0});

        run_bottle(4'd0, 3, 1'b1);

        start = 1'b1; stop = 1'b1;
        step(1);
        check_eq("start_stop_idle", outs(), {OnNone, 4'd1});
        stop = 1'b0;
        step(1);
        start = 1'b0;
        check_eq("start_again", outs(), {OnAdv, 4'd1});

        // Asynchronous reset in the middle of SEAL.
        bottle_at_fill = 1'b1;
        step(1);
        level_full = 1'b1;
        step(1);
        level_full = 1'b0;
        step(1);
        check_eq("pre_reset_seal", outs(), {OnSeal, 4'd1});
        #2 reset = 1'b0;
        #1 check_eq("async_reset", outs(), {OnNone, 4'd0});
        step(1);
        reset = 1'b1;
        step(1);
        check_eq("post_reset_idle", outs(), {OnNone, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/bottle_line_controller.md
# bottle_line_controller

Sequencing controller for the bottle filling line. It advances the conveyor, opens the fill valve until the level sensor trips, drives the capping press, and counts finished bottles into a crate of ten using a 0–9 wrap count. When the crate is full it holds the line until the operator acknowledges a crate change. It sits between the sensor/pushbutton front end (inputs already synchronized to `clk`) and the actuator drivers and display.

## Interface
- `FILL_TIMEOUT`, 200: max cycles in FILL without `level_full` before fault.
- `SEAL_CYCLES`, 8: cycles `cap_press` is held per bottle (≥1).
- `CRATE_SIZE`, 10: bottles per crate; count runs 0..`CRATE_SIZE`-1 (≤16).
- `clk` in 1: line clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces reset state immediately.
- `start` in 1: run request, level-sampled.
- `stop` in 1: stop request, level-sampled.
- `bottle_at_fill` in 1: bottle present under valve; rising edge counts.
- `level_full` in 1: fill level reached.
- `crate_ack` in 1: empty crate in place.
- `clear_fault` in 1: operator fault clear.
- `conveyor_on` out 1: conveyor motor enable.
- `valve_open` out 1: fill valve.
- `cap_press` out 1: capping press.
- `bottle_done` out 1: one-cycle pulse per completed bottle.
- `crate_full` out 1: crate complete, waiting for swap.
- `alarm` out 1: fill timeout fault.
- `count` out 4: bottles in current crate.

## Operation
- States: IDLE, ADVANCE, FILL, SEAL, COUNT, CRATE_WAIT, FAULT.
- Outputs are Moore decodes of the state register: ADVANCE→`conveyor_on`, FILL→`valve_open`, SEAL→`cap_press`, COUNT→`bottle_done`, CRATE_WAIT→`crate_full`, FAULT→`alarm`. At most one is high.
- IDLE: `start`=1 and `stop`=0 → ADVANCE. If both are 1, stop wins.
- ADVANCE: rising edge of `bottle_at_fill` (reg'd previous sample) → FILL. `stop` → IDLE.
- FILL: timer cleared on entry.
  - `level_full` → SEAL.
  - Otherwise, timer reaching `FILL_TIMEOUT`-1 → FAULT.
  - If both happen in the same cycle, `level_full` wins.
- SEAL: after `SEAL_CYCLES` cycles → COUNT.
- COUNT: single cycle.
  - If `count`=`CRATE_SIZE`-1, `count`←0 and next state is CRATE_WAIT.
  - Else `count`←`count`+1, then IDLE if `stop_pending`, otherwise ADVANCE.
- CRATE_WAIT: `crate_ack` → IDLE if `stop_pending`, otherwise ADVANCE.
- FAULT: all actuators off; `count` held. `clear_fault` → IDLE.
- `stop_pending`:
  - Set by `stop` in FILL, SEAL, COUNT or CRATE_WAIT.
  - Cleared on entry to IDLE.
  - A bottle in progress is always finished, never abandoned mid-fill.
- `count` changes only in COUNT or on reset.

## Timing
- Reset: state IDLE; all outputs 0; `count`=0; timer=0; `stop_pending`=0; edge register=0.
- Input-to-output latency is 1 cycle: an input sampled at edge N changes the state at N, and outputs reflect it after N.
- `bottle_at_fill` held high does not re-trigger; a new bottle needs 0 then 1.
- FILL dwell:
  - Minimum 1 cycle (`level_full` already high on entry → SEAL at the next edge).
  - Maximum `FILL_TIMEOUT` cycles.
- `cap_press` is high for exactly `SEAL_CYCLES` cycles.
- `bottle_done` is 1 cycle wide, in the same cycle the new `count` is visible.
- Reset asserted mid-operation clears everything asynchronously. `count` is lost; this is intended.

## Structure
- Shared package `garrafas_pkg`:
  - State encoding constants (3-bit).
  - Default values of `FILL_TIMEOUT`, `SEAL_CYCLES`, `CRATE_SIZE`.
- Sub-module `line_timer`:
  - Loadable up-counter with clear, `clk`/`reset` interface, and terminal-count compare output.
  - Used for both the FILL timeout and the SEAL dwell.
- The FSM, edge detect, `stop_pending` and `count` stay in the top module.

## Test plan
- Reset with `start`=1 held → all outputs 0, `count`=0. Release → ADVANCE next cycle, `conveyor_on`=1.
- Normal bottle:
  - Sensor edge → `valve_open` next cycle.
  - `level_full` after 5 cycles → `cap_press` high 8 cycles.
  - Then `bottle_done` pulse and `count` 0→1, then `conveyor_on`.
- Ten bottles:
  - 10th bottle → `count` 9→0 and `crate_full`=1, held while `crate_ack`=0.
  - `crate_ack` → ADVANCE.
- No `level_full`:
  - `alarm`=1 after 200 FILL cycles, `valve_open`=0, `count` unchanged.
  - `clear_fault` → IDLE.
- `stop` during FILL → bottle completes, `count` increments, then IDLE (not ADVANCE). `start`+`stop` together in IDLE → stays IDLE.
- `reset` pulled low during SEAL → outputs 0 and `count`=0 within the same cycle, without waiting for a clock edge. `bottle_at_fill` held high after a bottle → no second FILL.
